// File: rtl/exu_regfile_mp.sv
// EXU general-purpose register file: NRD combinational read ports, NWR write ports,
// per-register busy scoreboard, optional write-to-read bypass, post-reset zeroing.
module exu_regfile_mp #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned RFREG_NUM   = 32,
   parameter int unsigned RFIDX_WIDTH = 5,
   parameter int unsigned NRD         = 2,
   parameter int unsigned NWR         = 2,
   parameter int unsigned BYPASS      = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       init_done,
   input  logic [NRD*RFIDX_WIDTH-1:0] rd_idx,
   output logic [NRD*XLEN-1:0]        rd_data,
   output logic [NRD-1:0]             rd_busy,
   input  logic [NWR-1:0]             wr_ena,
   input  logic [NWR*RFIDX_WIDTH-1:0] wr_idx,
   input  logic [NWR*XLEN-1:0]        wr_data,
   input  logic                       issue_ena,
   input  logic [RFIDX_WIDTH-1:0]     issue_idx,
   input  logic                       flush,
   output logic [XLEN-1:0]            x1_data
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   localparam logic [RFIDX_WIDTH-1:0] LAST_IDX = RFIDX_WIDTH'(RFREG_NUM - 1);

   state_t                 state_q, state_d;
   logic [RFIDX_WIDTH-1:0] init_cnt_q, init_cnt_d;
   logic                   init_done_q, init_done_d;
   logic [RFREG_NUM-1:0]   busy_q, busy_d;
   logic [XLEN-1:0]        rf_q [RFREG_NUM];
   logic [XLEN-1:0]        rf_d [RFREG_NUM];

   logic [RFIDX_WIDTH-1:0] rd_idx_a  [NRD];
   logic [RFIDX_WIDTH-1:0] wr_idx_a  [NWR];
   logic [XLEN-1:0]        wr_data_a [NWR];
   logic [NWR-1:0]         wr_vld;

   always_comb begin
      for (int unsigned p = 0; p < NRD; p++) begin
         rd_idx_a[p] = rd_idx[p*RFIDX_WIDTH +: RFIDX_WIDTH];
      end
      for (int unsigned w = 0; w < NWR; w++) begin
         wr_idx_a[w]  = wr_idx[w*RFIDX_WIDTH +: RFIDX_WIDTH];
         wr_data_a[w] = wr_data[w*XLEN +: XLEN];
         wr_vld[w]    = (state_q == ST_RUN) && wr_ena[w] && (wr_idx_a[w] != '0);
      end
   end

   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      busy_d      = busy_q;
      rf_d        = rf_q;
      case (state_q)
         ST_INIT: begin
            rf_d[init_cnt_q] = '0;
            init_cnt_d       = init_cnt_q + RFIDX_WIDTH'(1);
            if (init_cnt_q == LAST_IDX) begin
               state_d     = ST_RUN;
               init_done_d = 1'b1;
            end
         end
         ST_RUN: begin
            // Ascending port order: the highest write port wins a shared index;
            // issue after write so a new producer keeps the register busy.
            for (int unsigned w = 0; w < NWR; w++) begin
               if (wr_vld[w]) begin
                  rf_d[wr_idx_a[w]]   = wr_data_a[w];
                  busy_d[wr_idx_a[w]] = 1'b0;
               end
            end
            if (issue_ena && (issue_idx != '0)) begin
               busy_d[issue_idx] = 1'b1;
            end
            if (flush) begin
               busy_d = '0;
            end
         end
         default: ;
      endcase
      busy_d[0] = 1'b0;
      rf_d[0]   = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= RFIDX_WIDTH'(1);
         init_done_q <= 1'b0;
         busy_q      <= '0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
         busy_q      <= busy_d;
      end
   end

   always_ff @(posedge clk) begin
      rf_q <= rf_d;
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int unsigned p = 0; p < NRD; p++) begin
         if ((state_q == ST_RUN) && (rd_idx_a[p] != '0)) begin
            rd_data[p*XLEN +: XLEN] = rf_q[rd_idx_a[p]];
            rd_busy[p]              = busy_q[rd_idx_a[p]];
            if (BYPASS != 0) begin
               for (int unsigned w = 0; w < NWR; w++) begin
                  if (wr_vld[w] && (wr_idx_a[w] == rd_idx_a[p])) begin
                     rd_data[p*XLEN +: XLEN] = wr_data_a[w];
                     rd_busy[p]              = 1'b0;
                  end
               end
            end
         end
      end
   end

   assign x1_data   = (state_q == ST_RUN) ? rf_q[1] : '0;
   assign init_done = init_done_q;

endmodule

// File: tb/tb_exu_regfile_mp.sv
// Bench for exu_regfile_mp: bypass and non-bypass instances driven in parallel,
// checked against a register-array reference model plus fixed expectation vectors.
module tb_exu_regfile_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  rd_idx;
   logic [1:0]  wr_ena;
   logic [9:0]  wr_idx;
   logic [63:0] wr_data;
   logic        issue_ena;
   logic [4:0]  issue_idx;
   logic        flush;

   logic        init_done, nb_init_done;
   logic [63:0] rd_data, nb_rd_data;
   logic [1:0]  rd_busy, nb_rd_busy;
   logic [31:0] x1_data, nb_x1_data;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   exu_regfile_mp #(.XLEN(32), .RFREG_NUM(32), .RFIDX_WIDTH(5), .NRD(2), .NWR(2), .BYPASS(1)) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_ena(wr_ena), .wr_idx(wr_idx), .wr_data(wr_data),
      .issue_ena(issue_ena), .issue_idx(issue_idx), .flush(flush),
      .x1_data(x1_data)
   );

   exu_regfile_mp #(.XLEN(32), .RFREG_NUM(32), .RFIDX_WIDTH(5), .NRD(2), .NWR(2), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst), .init_done(nb_init_done),
      .rd_idx(rd_idx), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
      .wr_ena(wr_ena), .wr_idx(wr_idx), .wr_data(wr_data),
      .issue_ena(issue_ena), .issue_idx(issue_idx), .flush(flush),
      .x1_data(nb_x1_data)
   );

   // Reference model: register array, busy flags, count of zeroing cycles left.
   logic [31:0] m_rf [32];
   bit   [31:0] m_bz;
   int          init_left = 31;

   function automatic logic [31:0] m_rd(input logic [4:0] idx, input bit byp);
      logic [31:0] v;
      if (init_left != 0 || idx == 5'd0) return 32'd0;
      v = m_rf[idx];
      if (byp) begin
         for (int w = 0; w < 2; w++)
            if (wr_ena[w] && wr_idx[w*5 +: 5] == idx) v = wr_data[w*32 +: 32];
      end
      return v;
   endfunction

   function automatic logic m_busy(input logic [4:0] idx, input bit byp);
      if (init_left != 0 || idx == 5'd0) return 1'b0;
      if (byp) begin
         for (int w = 0; w < 2; w++)
            if (wr_ena[w] && wr_idx[w*5 +: 5] == idx) return 1'b0;
      end
      return m_bz[idx];
   endfunction

   task automatic model_edge();
      if (rst) begin
         init_left = 31;
         m_bz      = '0;
      end else if (init_left > 0) begin
         m_rf[32 - init_left] = 32'd0;
         init_left--;
      end else begin
         for (int w = 0; w < 2; w++) begin
            if (wr_ena[w] && wr_idx[w*5 +: 5] != 5'd0) begin
               m_rf[wr_idx[w*5 +: 5]] = wr_data[w*32 +: 32];
               m_bz[wr_idx[w*5 +: 5]] = 1'b0;
            end
         end
         if (issue_ena && issue_idx != 5'd0) m_bz[issue_idx] = 1'b1;
         if (flush) m_bz = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_model();
      chk("rd0",       rd_data[31:0],     m_rd(rd_idx[4:0], 1'b1));
      chk("rd1",       rd_data[63:32],    m_rd(rd_idx[9:5], 1'b1));
      chk("busy0",     32'(rd_busy[0]),   32'(m_busy(rd_idx[4:0], 1'b1)));
      chk("busy1",     32'(rd_busy[1]),   32'(m_busy(rd_idx[9:5], 1'b1)));
      chk("x1",        x1_data,           (init_left != 0) ? 32'd0 : m_rf[1]);
      chk("init_done", 32'(init_done),    32'(init_left == 0));
      chk("nb_rd0",    nb_rd_data[31:0],  m_rd(rd_idx[4:0], 1'b0));
      chk("nb_rd1",    nb_rd_data[63:32], m_rd(rd_idx[9:5], 1'b0));
      chk("nb_busy0",  32'(nb_rd_busy[0]), 32'(m_busy(rd_idx[4:0], 1'b0)));
      chk("nb_busy1",  32'(nb_rd_busy[1]), 32'(m_busy(rd_idx[9:5], 1'b0)));
      chk("nb_x1",     nb_x1_data,        (init_left != 0) ? 32'd0 : m_rf[1]);
      chk("nb_init",   32'(nb_init_done), 32'(init_left == 0));
   endtask

   task automatic set_in(input logic [1:0] we, input logic [4:0] wi0, input logic [31:0] wd0,
                         input logic [4:0] wi1, input logic [31:0] wd1, input logic iss,
                         input logic [4:0] ii, input logic fl, input logic [4:0] ri0,
                         input logic [4:0] ri1);
      wr_ena    = we;
      wr_idx    = {wi1, wi0};
      wr_data   = {wd1, wd0};
      issue_ena = iss;
      issue_idx = ii;
      flush     = fl;
      rd_idx    = {ri1, ri0};
   endtask

   // After a one-cycle reset: 31 cycles with init_done low, then high, with
   // writes/issues/flush driven throughout to show they are ignored.
   task automatic init_window(input string tag);
      for (int c = 1; c <= 31; c++) begin
         set_in(2'b11, 5'(c), $urandom, 5'd1, $urandom, 1'b1, 5'(c), 1'b0,
                5'($urandom_range(1, 31)), 5'd1);
         #2;
         chk({tag, "_low"}, 32'(init_done), 32'd0);
         chk_model();
         tick();
      end
      set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd31, 5'd1);
      #2;
      chk({tag, "_high"}, 32'(init_done), 32'd1);
      chk({tag, "_rd31"}, rd_data[31:0], 32'd0);
      chk_model();
   endtask

   typedef struct {
      logic [1:0]  we;
      logic [4:0]  wi0;
      logic [31:0] wd0;
      logic [4:0]  wi1;
      logic [31:0] wd1;
      logic        iss;
      logic [4:0]  ii;
      logic        fl;
      logic [4:0]  ri0, ri1;
      logic [31:0] e_rd0, e_rd1;
      logic        e_bz0, e_bz1;
      logic [31:0] e_x1;
   } vec_t;

   vec_t vt [16];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vt[0]  = '{2'b11, 5'd5, 32'hDEADBEEF, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0, 5'd5, 5'd1, 32'h12345678, 32'h0, 1'b0, 1'b0, 32'h0};
      vt[1]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 1'b0, 1'b0, 32'h0};
      vt[2]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd7, 5'd5, 32'h0, 32'h12345678, 1'b0, 1'b0, 32'h0};
      vt[3]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0};
      vt[4]  = '{2'b01, 5'd7, 32'hA5, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd5, 32'hA5, 32'h12345678, 1'b0, 1'b0, 32'h0};
      vt[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7, 32'hA5, 32'hA5, 1'b0, 1'b0, 32'h0};
      vt[6]  = '{2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0, 5'd9, 5'd7, 32'h99, 32'hA5, 1'b0, 1'b0, 32'h0};
      vt[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd9, 5'd9, 32'h99, 32'h99, 1'b1, 1'b1, 32'h0};
      vt[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd3, 5'd9, 32'h0, 32'h99, 1'b0, 1'b1, 32'h0};
      vt[9]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd3, 5'd9, 32'h0, 32'h99, 1'b0, 1'b0, 32'h0};
      vt[10] = '{2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      vt[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0};
      vt[12] = '{2'b10, 5'd0, 32'h0, 5'd1, 32'hCAFE, 1'b0, 5'd0, 1'b0, 5'd1, 5'd5, 32'hCAFE, 32'h12345678, 1'b0, 1'b0, 32'h0};
      vt[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd1, 5'd0, 32'hCAFE, 32'h0, 1'b0, 1'b0, 32'hCAFE};
      vt[14] = '{2'b01, 5'd4, 32'h55, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd1, 32'h55, 32'hCAFE, 1'b0, 1'b0, 32'hCAFE};
      vt[15] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd4, 32'h55, 32'h55, 1'b0, 1'b0, 32'hCAFE};

      set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);

      // Power-up reset and full zeroing window.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      init_window("init");

      // Reset again, then re-reset on the tenth zeroing cycle.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 1; c < 10; c++) begin
         #2;
         chk("mid_low", 32'(init_done), 32'd0);
         tick();
      end
      rst = 1'b1;
      #2;
      chk("mid_rst_low", 32'(init_done), 32'd0);
      tick();
      rst = 1'b0;
      init_window("reinit");

      // Fixed vectors on the bypass instance; the model also covers BYPASS=0.
      for (int i = 0; i < 16; i++) begin
         set_in(vt[i].we, vt[i].wi0, vt[i].wd0, vt[i].wi1, vt[i].wd1, vt[i].iss,
                vt[i].ii, vt[i].fl, vt[i].ri0, vt[i].ri1);
         #2;
         chk($sformatf("vec%0d_rd0", i),  rd_data[31:0],   vt[i].e_rd0);
         chk($sformatf("vec%0d_rd1", i),  rd_data[63:32],  vt[i].e_rd1);
         chk($sformatf("vec%0d_bz0", i),  32'(rd_busy[0]), 32'(vt[i].e_bz0));
         chk($sformatf("vec%0d_bz1", i),  32'(rd_busy[1]), 32'(vt[i].e_bz1));
         chk($sformatf("vec%0d_x1", i),   x1_data,         vt[i].e_x1);
         chk_model();
         tick();
      end

      // Non-bypass build: a write is invisible until the following cycle.
      set_in(2'b01, 5'd4, 32'h66, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd4);
      #2;
      chk("nb_same_cycle", nb_rd_data[31:0], 32'h55);
      chk("byp_same_cycle", rd_data[31:0], 32'h66);
      tick();
      set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd4, 5'd4);
      #2;
      chk("nb_next_cycle", nb_rd_data[31:0], 32'h66);
      tick();

      // Both ports to the same index: port 1 must land in the register.
      set_in(2'b11, 5'd6, 32'h1111, 5'd6, 32'h2222, 1'b0, 5'd0, 1'b0, 5'd6, 5'd6);
      tick();
      set_in(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd6, 5'd6);
      #2;
      chk("nb_port1_wins", nb_rd_data[31:0], 32'h2222);
      tick();

      // Randomised traffic with occasional flush and rare reset.
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 399) == 0);
         set_in(2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 7)),
                ($urandom_range(0, 9) == 0),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         #2;
         chk_model();
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
